mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline, directly downstream of the execute stage.
- Consumes the execute-stage output bundle (ex_stage_out_t) and performs loads, stores and RV32A atomics over a valid/ready data-memory port.
- Registers the result toward writeback and drives the mem-to-ex forwarding bundle (ex_stage_in_frm_mem_t).
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- DMEM_AW, 32, data-memory byte-address width.
- RESV_EN, 1, enables the LR/SC reservation register (0: every SC fails).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- ex_in  in  ex_stage_out_t  execute result, control and operands.
- ex_valid  in  1  ex_in holds a live instruction.
- mem_stall  out  1  hold EX/ID/IF; ex_in must stay stable while high.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_addr  out  DMEM_AW  word-aligned address (bits [1:0] = 0).
- dmem_we  out  1  write request.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-aligned write data.
- dmem_rsp_valid  in  1  read data or write acknowledge returned.
- dmem_rdata  in  32  read data.
- wb_valid  out  1  registered result valid.
- wb_out  out  {rd[4:0], rf_en, wb_sel[1:0], wb_data[31:0], pc4[31:0], csr fields}  registered to writeback.
- fwd_out  out  ex_stage_in_frm_mem_t  combinational {rf_en & ex_valid, rd, opr_res} of the current ex_in.
- misalign  out  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset: FSM IDLE; wb_valid, dmem_req_valid, mem_stall, misalign and the reservation valid bit all 0; wb_out is 0.
- Address is opr_res. Store data and the AMO source operand are opr_b.
- Non-memory op (dm_en=0 and amoop=NONE): no stall; ex_in is registered to wb_out in 1 cycle; wb_data = opr_res.
- FSM states: IDLE, REQ, RSP, AMO_WREQ, AMO_WRSP.
- IDLE → REQ: ex_valid with a memory op. mem_stall rises combinationally in the same cycle.
- REQ: dmem_req_valid held, with addr/we/be/wdata stable until dmem_req_ready. On handshake → RSP.
- RSP: wait for dmem_rsp_valid.
  - Load or store: → IDLE; capture result; wb_valid=1 the next cycle; mem_stall drops in the cycle rsp_valid is seen.
  - AMO read: → AMO_WREQ with the old value latched.
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend. The lane is selected by addr[1:0]; LW uses the whole word.
- Store lanes: SB be = 4'b0001<<addr[1:0]. SH be = 4'b0011<<addr[1:0]. SW be = 4'hF. Data is replicated across lanes.
- Misaligned (halfword with addr[0]=1, or word/AMO with addr[1:0]≠0):
  - No dmem request; misalign pulses.
  - Instruction retires with rf_en forced to 0; 1-cycle latency.
- AMO ops SWAP/ADD/XOR/AND/OR/MIN/MAX/MINU/MAXU:
  - Read old value, compute new = f(old, opr_b) (MIN/MAX signed, MINU/MAXU unsigned), write word with be=4'hF.
  - rd receives the old value.
  - The read and write are not interleaved with any other request.
- LR: word read; sets reservation valid and reservation address = addr[31:2].
- SC:
  - Success when reservation valid and the address matches: write, then rd=0.
  - Failure: no dmem request, rd=1, 1-cycle latency.
  - Any SC clears the reservation.
- A regular store or AMO write to the reserved word clears the reservation.
- wb_valid is a one-cycle pulse per retired instruction. It is 0 in cycles where ex_valid=0 or the stage is stalled mid-transaction.
- Simultaneous dmem_req_ready and dmem_rsp_valid in one cycle are legal; the response is honoured only in RSP/AMO_WRSP.
- dmem_rsp_valid seen in IDLE/REQ is ignored.
- Reset mid-transaction: FSM returns to IDLE, outputs clear, the reservation clears, and late responses are ignored.

Test Plan:
- ADD, opr_res=0x1234, rf_en=1, no memory op → next cycle wb_valid=1, wb_data=0x1234, mem_stall never high.
- LB from addr 0x103, dmem_rdata=0x80FF_FF00, ready delayed 2 cycles, rsp 1 cycle later → dmem_addr=0x100, mem_stall high for 4 cycles, wb_data=0xFFFF_FF80.
- SH, addr 0x202, opr_b=0x0000_ABCD → be=4'b1100, wdata=0xABCD_ABCD, we=1, rf_en=0 at wb.
- AMOADD, addr 0x40, memory holds 5, opr_b=3 → read then write of 8 with be=4'hF; wb_data=5.
- LR at 0x80, then SC at 0x80 → SC writes, rd=0. Repeat SC at 0x80 → no request, rd=1. LR at 0x80, SW at 0x80, SC → rd=1.
- LW at addr 0x6 → misalign pulse, no dmem_req_valid, rf_en=0. Assert rst_n=0 while in RSP → all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; loads, stores and RV32A atomics over a valid/ready data port,
// registered result toward writeback and combinational forwarding of the current execute result.
package mem_stage_pkg;
    localparam logic [3:0] AMO_NONE = 4'd0, AMO_SWAP = 4'd1, AMO_ADD = 4'd2, AMO_XOR = 4'd3,
                           AMO_AND = 4'd4, AMO_OR = 4'd5, AMO_MIN = 4'd6, AMO_MAX = 4'd7,
                           AMO_MINU = 4'd8, AMO_MAXU = 4'd9, AMO_LR = 4'd10, AMO_SC = 4'd11;
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] opr_res;
        logic [31:0] opr_b;
        logic [4:0]  rd;
        logic        rf_en;
        logic [1:0]  wb_sel;
        logic        dm_en;
        logic        dm_we;
        logic [2:0]  dm_fn3;
        logic [3:0]  amoop;
        logic [11:0] csr_addr;
        logic        csr_we;
        logic [31:0] csr_wdata;
    } ex_stage_out_t;
    typedef struct packed {
        logic        rf_en;
        logic [4:0]  rd;
        logic [31:0] opr_res;
    } ex_stage_in_frm_mem_t;
    typedef struct packed {
        logic [4:0]  rd;
        logic        rf_en;
        logic [1:0]  wb_sel;
        logic [31:0] wb_data;
        logic [31:0] pc4;
        logic [11:0] csr_addr;
        logic        csr_we;
        logic [31:0] csr_wdata;
    } wb_out_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_AW = 32,
    parameter bit RESV_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  ex_stage_out_t        ex_in,
    input  logic                 ex_valid,
    output logic                 mem_stall,
    output logic                 dmem_req_valid,
    input  logic                 dmem_req_ready,
    output logic [DMEM_AW-1:0]   dmem_addr,
    output logic                 dmem_we,
    output logic [3:0]           dmem_be,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_rsp_valid,
    input  logic [31:0]          dmem_rdata,
    output logic                 wb_valid,
    output wb_out_t              wb_out,
    output ex_stage_in_frm_mem_t fwd_out,
    output logic                 misalign
);
    localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, RSP = 3'd2, AMO_WREQ = 3'd3, AMO_WRSP = 3'd4;

    logic [2:0]  state, state_nx;
    logic [31:0] addr, old, amo_new, lane, ld_data, st_data, wb_data;
    logic [3:0]  st_be;
    logic [29:0] resv_addr;
    logic        resv_valid, resv_hit;
    logic        is_amo, is_lr, is_sc, amo_rmw, is_st, is_ld, half, word, mis, sc_fail;
    logic        start, done, retire, st_req;
    wb_out_t     wb_nx;

    assign addr     = ex_in.opr_res;
    assign is_amo   = ex_in.amoop != AMO_NONE;
    assign is_lr    = ex_in.amoop == AMO_LR;
    assign is_sc    = ex_in.amoop == AMO_SC;
    assign amo_rmw  = is_amo & !is_lr & !is_sc;
    assign is_st    = ex_in.dm_en & ex_in.dm_we & !is_amo;
    assign is_ld    = ex_in.dm_en & !ex_in.dm_we & !is_amo;
    assign half     = ex_in.dm_en & !is_amo & (ex_in.dm_fn3[1:0] == 2'b01);
    assign word     = is_amo | (ex_in.dm_en & ex_in.dm_fn3[1]);
    assign mis      = (half & addr[0]) | (word & (addr[1:0] != 2'b00));
    assign resv_hit = RESV_EN & resv_valid & (resv_addr == addr[31:2]);
    assign sc_fail  = is_sc & !resv_hit;

    // ex_in is held stable by mem_stall, so it serves as the transaction record throughout
    assign start     = (state == IDLE) & ex_valid & (ex_in.dm_en | is_amo) & !mis & !sc_fail;
    assign done      = dmem_rsp_valid & ((state == AMO_WRSP) | ((state == RSP) & !amo_rmw));
    assign retire    = ((state == IDLE) & ex_valid & !start) | done;
    assign mem_stall = start | ((state != IDLE) & !done);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = start ? REQ : IDLE;
            REQ:      state_nx = dmem_req_ready ? RSP : REQ;
            RSP:      state_nx = !dmem_rsp_valid ? RSP : amo_rmw ? AMO_WREQ : IDLE;
            AMO_WREQ: state_nx = dmem_req_ready ? AMO_WRSP : AMO_WREQ;
            AMO_WRSP: state_nx = dmem_rsp_valid ? IDLE : AMO_WRSP;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        amo_new = ex_in.opr_b;
        case (ex_in.amoop)
            AMO_ADD:  amo_new = old + ex_in.opr_b;
            AMO_XOR:  amo_new = old ^ ex_in.opr_b;
            AMO_AND:  amo_new = old & ex_in.opr_b;
            AMO_OR:   amo_new = old | ex_in.opr_b;
            AMO_MIN:  amo_new = ($signed(old) < $signed(ex_in.opr_b)) ? old : ex_in.opr_b;
            AMO_MAX:  amo_new = ($signed(old) > $signed(ex_in.opr_b)) ? old : ex_in.opr_b;
            AMO_MINU: amo_new = (old < ex_in.opr_b) ? old : ex_in.opr_b;
            AMO_MAXU: amo_new = (old > ex_in.opr_b) ? old : ex_in.opr_b;
            default:  amo_new = ex_in.opr_b;
        endcase
    end

    assign lane    = dmem_rdata >> {addr[1:0], 3'b000};
    assign ld_data = (is_lr | ex_in.dm_fn3[1]) ? dmem_rdata :
                     ex_in.dm_fn3[0] ? {{16{~ex_in.dm_fn3[2] & lane[15]}}, lane[15:0]} :
                                       {{24{~ex_in.dm_fn3[2] & lane[7]}}, lane[7:0]};
    assign st_be   = word ? 4'hF : half ? (4'b0011 << addr[1:0]) : (4'b0001 << addr[1:0]);
    assign st_data = word ? ex_in.opr_b : half ? {2{ex_in.opr_b[15:0]}} : {4{ex_in.opr_b[7:0]}};

    assign st_req         = (state == REQ) & (is_st | is_sc);
    assign dmem_req_valid = (state == REQ) | (state == AMO_WREQ);
    assign dmem_addr      = dmem_req_valid ? {addr[DMEM_AW-1:2], 2'b00} : '0;
    assign dmem_we        = st_req | (state == AMO_WREQ);
    assign dmem_be        = !dmem_req_valid ? 4'h0 : st_req ? st_be : 4'hF;
    assign dmem_wdata     = (state == AMO_WREQ) ? amo_new : st_req ? st_data : 32'd0;

    // An SC retiring from IDLE is always the failed path; one retiring after a write succeeded
    assign wb_data = is_sc ? {31'd0, state == IDLE} :
                     amo_rmw ? old :
                     ((is_ld | is_lr) & !mis) ? ld_data : ex_in.opr_res;
    assign wb_nx   = '{rd: ex_in.rd, rf_en: ex_in.rf_en & !mis & !is_st, wb_sel: ex_in.wb_sel,
                       wb_data: wb_data, pc4: ex_in.pc4, csr_addr: ex_in.csr_addr,
                       csr_we: ex_in.csr_we, csr_wdata: ex_in.csr_wdata};
    assign fwd_out = '{rf_en: ex_in.rf_en & ex_valid, rd: ex_in.rd, opr_res: ex_in.opr_res};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wb_valid   <= 1'b0;
            misalign   <= 1'b0;
            wb_out     <= '0;
            old        <= '0;
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else begin
            state    <= state_nx;
            wb_valid <= retire;
            misalign <= (state == IDLE) & ex_valid & mis;
            if (retire)
                wb_out <= wb_nx;
            if ((state == RSP) & dmem_rsp_valid)
                old <= dmem_rdata;
            if ((state == RSP) & dmem_rsp_valid & is_lr) begin
                resv_valid <= RESV_EN;
                resv_addr  <= addr[31:2];
            end else if ((state == IDLE) & ex_valid &
                         (is_sc | ((is_st | amo_rmw) & !mis & (resv_addr == addr[31:2]))))
                resv_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage with a small valid/ready memory responder.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n, ex_valid, mem_stall;
    ex_stage_out_t        ex;
    logic                 dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
    logic [31:0]          dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]           dmem_be;
    logic                 wb_valid, misalign;
    wb_out_t              wb_out;
    ex_stage_in_frm_mem_t fwd_out;

    int          checks = 0, failures = 0, stalls, n_req;
    logic        first_we, r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;

    mem_stage #(.DMEM_AW(32), .RESV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ex_in(ex), .ex_valid(ex_valid), .mem_stall(mem_stall),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
        .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_out(wb_out), .fwd_out(fwd_out), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic op(input logic [31:0] res, input logic [31:0] b, input logic [4:0] rd,
                      input logic rfe, input logic dm, input logic we, input logic [2:0] fn3,
                      input logic [3:0] amo);
        ex = '0;
        ex.opr_res = res; ex.opr_b = b; ex.rd = rd; ex.rf_en = rfe;
        ex.dm_en = dm; ex.dm_we = we; ex.dm_fn3 = fn3; ex.amoop = amo;
        ex.pc4 = 32'h1000;
        ex_valid = 1'b1;
    endtask

    // Holds the op until the stage stops stalling; ready after dly waiting cycles, response one cycle later
    task automatic run(input int dly, input logic [31:0] rdata);
        int  w;
        bit  pend, fin;
        w = 0; pend = 0; fin = 0; stalls = 0; n_req = 0; first_we = 0;
        dmem_rdata = rdata;
        for (int c = 0; c < 40 && !fin; c++) begin
            dmem_rsp_valid = pend;
            if (pend) w = 0;
            pend = 0;
            dmem_req_ready = 1'b0;
            #1;
            if (dmem_req_valid) begin
                if (w == dly) begin
                    dmem_req_ready = 1'b1;
                    pend = 1;
                    if (n_req == 0) first_we = dmem_we;
                    n_req++;
                    r_addr = dmem_addr; r_we = dmem_we; r_be = dmem_be; r_wdata = dmem_wdata;
                end else w++;
            end
            if (mem_stall) stalls++; else fin = 1;
            step();
        end
        dmem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b0;
        ex_valid = 1'b0;
        chk("op_completes", 32'(fin), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; ex = '0; ex_valid = 1'b0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
        step(); step();
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_stall", 32'(mem_stall), 0);
        chk("rst_req", 32'(dmem_req_valid), 0);
        chk("rst_misalign", 32'(misalign), 0);
        chk("rst_wb_out", 32'(wb_out == '0), 1);
        rst_n = 1'b1;

        op(32'h1234, 0, 5'd5, 1, 0, 0, 3'b000, AMO_NONE); run(0, 0);
        chk("add_stalls", stalls, 0);
        chk("add_wb_valid", 32'(wb_valid), 1);
        chk("add_wb_data", wb_out.wb_data, 32'h1234);
        chk("add_rf_en", 32'(wb_out.rf_en), 1);
        chk("add_rd", 32'(wb_out.rd), 5);
        step();
        chk("add_wb_pulse", 32'(wb_valid), 0);

        op(32'h103, 0, 5'd6, 1, 1, 0, 3'b000, AMO_NONE); run(2, 32'h80FF_FF00);
        chk("lb_stalls", stalls, 4);
        chk("lb_addr", r_addr, 32'h100);
        chk("lb_we", 32'(r_we), 0);
        chk("lb_wb_valid", 32'(wb_valid), 1);
        chk("lb_data", wb_out.wb_data, 32'hFFFF_FF80);

        op(32'h102, 0, 5'd6, 1, 1, 0, 3'b101, AMO_NONE); run(0, 32'h8001_0000);
        chk("lhu_data", wb_out.wb_data, 32'h0000_8001);
        op(32'h102, 0, 5'd6, 1, 1, 0, 3'b001, AMO_NONE); run(1, 32'h8001_0000);
        chk("lh_data", wb_out.wb_data, 32'hFFFF_8001);

        op(32'h202, 32'h0000_ABCD, 5'd7, 1, 1, 1, 3'b001, AMO_NONE); run(0, 0);
        chk("sh_be", 32'(r_be), 32'hC);
        chk("sh_wdata", r_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(r_we), 1);
        chk("sh_addr", r_addr, 32'h200);
        chk("sh_rf_en", 32'(wb_out.rf_en), 0);
        chk("sh_stalls", stalls, 2);

        op(32'h201, 32'h1234_5678, 5'd7, 0, 1, 1, 3'b000, AMO_NONE); run(0, 0);
        chk("sb_be", 32'(r_be), 32'h2);
        chk("sb_wdata", r_wdata, 32'h7878_7878);

        op(32'h40, 32'd3, 5'd8, 1, 0, 0, 3'b010, AMO_ADD); run(0, 32'd5);
        chk("amoadd_nreq", n_req, 2);
        chk("amoadd_rd_first", 32'(first_we), 0);
        chk("amoadd_we", 32'(r_we), 1);
        chk("amoadd_wdata", r_wdata, 32'd8);
        chk("amoadd_be", 32'(r_be), 32'hF);
        chk("amoadd_addr", r_addr, 32'h40);
        chk("amoadd_old", wb_out.wb_data, 32'd5);
        chk("amoadd_stalls", stalls, 4);

        op(32'h44, 32'd1, 5'd8, 1, 0, 0, 3'b010, AMO_MAX); run(1, 32'hFFFF_FFFE);
        chk("amomax_wdata", r_wdata, 32'd1);
        chk("amomax_old", wb_out.wb_data, 32'hFFFF_FFFE);
        op(32'h44, 32'd1, 5'd8, 1, 0, 0, 3'b010, AMO_MAXU); run(0, 32'hFFFF_FFFE);
        chk("amomaxu_wdata", r_wdata, 32'hFFFF_FFFE);

        op(32'h80, 0, 5'd9, 1, 0, 0, 3'b010, AMO_LR); run(0, 32'h77);
        chk("lr_data", wb_out.wb_data, 32'h77);
        chk("lr_we", 32'(r_we), 0);
        op(32'h80, 32'h99, 5'd10, 1, 0, 0, 3'b010, AMO_SC); run(0, 0);
        chk("sc_ok_nreq", n_req, 1);
        chk("sc_ok_we", 32'(r_we), 1);
        chk("sc_ok_wdata", r_wdata, 32'h99);
        chk("sc_ok_rd", wb_out.wb_data, 0);
        op(32'h80, 32'h99, 5'd10, 1, 0, 0, 3'b010, AMO_SC); run(0, 0);
        chk("sc_again_nreq", n_req, 0);
        chk("sc_again_rd", wb_out.wb_data, 1);
        chk("sc_again_stalls", stalls, 0);

        op(32'h80, 0, 5'd9, 1, 0, 0, 3'b010, AMO_LR); run(0, 32'h1);
        op(32'h80, 32'h55, 5'd0, 0, 1, 1, 3'b010, AMO_NONE); run(0, 0);
        op(32'h80, 32'h99, 5'd10, 1, 0, 0, 3'b010, AMO_SC); run(0, 0);
        chk("sc_after_sw_nreq", n_req, 0);
        chk("sc_after_sw_rd", wb_out.wb_data, 1);

        op(32'h80, 0, 5'd9, 1, 0, 0, 3'b010, AMO_LR); run(0, 32'h1);
        op(32'h84, 32'h55, 5'd0, 0, 1, 1, 3'b010, AMO_NONE); run(0, 0);
        op(32'h80, 32'h99, 5'd10, 1, 0, 0, 3'b010, AMO_SC); run(0, 0);
        chk("sc_other_word_rd", wb_out.wb_data, 0);

        op(32'h6, 0, 5'd11, 1, 1, 0, 3'b010, AMO_NONE); run(0, 0);
        chk("mis_lw_nreq", n_req, 0);
        chk("mis_lw_pulse", 32'(misalign), 1);
        chk("mis_lw_rf_en", 32'(wb_out.rf_en), 0);
        chk("mis_lw_wb_valid", 32'(wb_valid), 1);
        step();
        chk("mis_pulse_end", 32'(misalign), 0);
        op(32'h101, 0, 5'd11, 1, 1, 0, 3'b001, AMO_NONE); run(0, 0);
        chk("mis_lh_pulse", 32'(misalign), 1);

        op(32'h80, 0, 5'd9, 1, 0, 0, 3'b010, AMO_LR); run(0, 32'h1);
        op(32'h300, 0, 5'd12, 1, 1, 0, 3'b010, AMO_NONE);
        #1 chk("rsp_rst_stall_idle", 32'(mem_stall), 1);
        step();
        dmem_req_ready = 1'b1;
        #1 chk("rsp_rst_req", 32'(dmem_req_valid), 1);
        step();
        dmem_req_ready = 1'b0;
        #1 chk("rsp_rst_in_rsp", 32'(mem_stall), 1);
        rst_n = 1'b0; ex_valid = 1'b0;
        step();
        chk("rst_mid_req", 32'(dmem_req_valid), 0);
        chk("rst_mid_stall", 32'(mem_stall), 0);
        chk("rst_mid_wb_valid", 32'(wb_valid), 0);
        chk("rst_mid_wb_out", 32'(wb_out == '0), 1);
        chk("rst_mid_addr", dmem_addr, 0);
        rst_n = 1'b1; dmem_rsp_valid = 1'b1;
        step();
        dmem_rsp_valid = 1'b0;
        chk("late_rsp_wb_valid", 32'(wb_valid), 0);
        chk("late_rsp_stall", 32'(mem_stall), 0);
        op(32'h80, 32'h99, 5'd10, 1, 0, 0, 3'b010, AMO_SC); run(0, 0);
        chk("sc_after_rst_rd", wb_out.wb_data, 1);
        chk("sc_after_rst_nreq", n_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
